// File: rtl/gerador_papeis_pkg.sv
// Purpose: shared role codes, FSM state codes and LFSR step for the role drawer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package polilobinho_pkg;

  typedef enum logic [1:0] {
    PAPEL_ALDEAO    = 2'b00,
    PAPEL_LOBO      = 2'b01,
    PAPEL_MEDICO    = 2'b10,
    PAPEL_RESERVADO = 2'b11
  } papel_t;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'd0,
    ST_CARREGA = 5'd1,
    ST_LOBOS   = 5'd2,
    ST_MEDICO  = 5'd3,
    ST_FIM     = 5'd4
  } estado_t;

  // Reported on db_estado when the state register holds an unused code.
  localparam logic [4:0] DB_ERRO    = 5'b11111;
  localparam logic [7:0] LFSR_RESET = 8'h01;

  // x^8+x^6+x^5+x^4+1, shifting left with the feedback entering bit 0.
  function automatic logic [7:0] lfsr_prox(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/gerador_papeis_if.sv
// Purpose: request/lookup/result bundle of the role drawer.
// Latency: n/a (wires only).
// Backpressure: none; sorteia is a one-cycle request ignored while busy.
interface gerador_papeis_if #(
  parameter int N_JOG = 5
);
  logic                 sorteia;
  logic [7:0]           seed;
  logic [2:0]           jogador;
  logic [2*N_JOG-1:0]   papeis;
  logic [1:0]           papel;
  logic                 ocupado;
  logic                 valido;
  logic                 pronto;
  logic [4:0]           db_estado;

  modport master (
    output sorteia, seed, jogador,
    input  papeis, papel, ocupado, valido, pronto, db_estado
  );

  modport slave (
    input  sorteia, seed, jogador,
    output papeis, papel, ocupado, valido, pronto, db_estado
  );
endinterface

// File: rtl/gerador_papeis_lfsr8.sv
// Purpose: 8-bit maximal-length LFSR with seed load (zero seed remapped to 8'h01).
// Latency: new value visible one cycle after carrega/avanca.
// Backpressure: none; carrega wins over avanca.
import polilobinho_pkg::*;

module lfsr8 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       carrega,
  input  logic [7:0] valor,
  input  logic       avanca,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Next LFSR value: load seed (never the all-zero lockup state) or step.
  always_comb begin
    lfsr_d = lfsr_q;
    if (carrega) begin
      lfsr_d = (valor == 8'h00) ? LFSR_RESET : valor;
    end else if (avanca) begin
      lfsr_d = lfsr_prox(lfsr_q);
    end
  end

  // LFSR register with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset_n) lfsr_q <= LFSR_RESET;
    else          lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/gerador_papeis.sv
// Purpose: draws N_LOBOS wolves and optionally one doctor among N_JOG players.
// Latency: 1+N_LOBOS+HAS_MEDICO+1 cycles from accepted sorteia to pronto, +1 per collision.
// Backpressure: sorteia accepted only in IDLE/FIM; ocupado flags the busy window.
import polilobinho_pkg::*;

module gerador_papeis #(
  parameter int N_JOG      = 5,
  parameter int N_LOBOS    = 1,
  parameter int HAS_MEDICO = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  gerador_papeis_if.slave   bus
);

  localparam int W = 2 * N_JOG;

  estado_t      estado_q,   estado_d;
  logic [W-1:0] papeis_q,   papeis_d;
  logic [3:0]   restante_q, restante_d;
  logic         valido_q,   valido_d;
  logic         pronto_q,   pronto_d;
  logic         ocupado_q,  ocupado_d;

  logic [7:0]   lfsr;
  logic [2:0]   cand;
  int           cand_lsb;
  logic [1:0]   papel_cand;
  logic         aceita;
  logic         avanca;

  assign aceita = bus.sorteia && (estado_q == ST_IDLE || estado_q == ST_FIM);
  assign avanca = (estado_q == ST_LOBOS) || (estado_q == ST_MEDICO);

  lfsr8 u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .carrega (aceita),
    .valor   (bus.seed),
    .avanca  (avanca),
    .q       (lfsr)
  );

  // Candidate player and its current role; player 0 sits in the MSBs.
  assign cand       = 3'(lfsr % 8'(N_JOG));
  assign cand_lsb   = 2 * (N_JOG - 1 - int'(cand));
  assign papel_cand = papeis_q[cand_lsb +: 2];

  // Next-state and datapath updates of the draw FSM.
  always_comb begin
    estado_d   = estado_q;
    papeis_d   = papeis_q;
    restante_d = restante_q;
    valido_d   = valido_q;
    case (estado_q)
      ST_IDLE, ST_FIM: begin
        if (bus.sorteia) estado_d = ST_CARREGA;
      end
      ST_CARREGA: begin
        papeis_d   = '0;
        valido_d   = 1'b0;
        restante_d = 4'(N_LOBOS);
        estado_d   = ST_LOBOS;
      end
      ST_LOBOS: begin
        if (papel_cand == PAPEL_ALDEAO) begin
          papeis_d[cand_lsb +: 2] = PAPEL_LOBO;
          restante_d = restante_q - 4'd1;
          if (restante_q == 4'd1) estado_d = (HAS_MEDICO != 0) ? ST_MEDICO : ST_FIM;
        end
      end
      ST_MEDICO: begin
        if (papel_cand == PAPEL_ALDEAO) begin
          papeis_d[cand_lsb +: 2] = PAPEL_MEDICO;
          estado_d = ST_FIM;
        end
      end
      default: estado_d = ST_IDLE;
    endcase
    if (estado_d == ST_FIM) valido_d = 1'b1;
    ocupado_d = (estado_d == ST_CARREGA) || (estado_d == ST_LOBOS) || (estado_d == ST_MEDICO);
    pronto_d  = (estado_d == ST_FIM) && (estado_q != ST_FIM);
  end

  // FSM state and registered outputs; reset discards any partial draw.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado_q   <= ST_IDLE;
      papeis_q   <= '0;
      restante_q <= 4'd0;
      valido_q   <= 1'b0;
      pronto_q   <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      papeis_q   <= papeis_d;
      restante_q <= restante_d;
      valido_q   <= valido_d;
      pronto_q   <= pronto_d;
      ocupado_q  <= ocupado_d;
    end
  end

  // Debug state code and per-player lookup.
  always_comb begin
    case (estado_q)
      ST_IDLE, ST_CARREGA, ST_LOBOS, ST_MEDICO, ST_FIM: bus.db_estado = estado_q;
      default:                                          bus.db_estado = DB_ERRO;
    endcase
    bus.papel = 2'b00;
    if (int'(bus.jogador) < N_JOG) begin
      bus.papel = papeis_q[2 * (N_JOG - 1 - int'(bus.jogador)) +: 2];
    end
  end

  assign bus.papeis  = papeis_q;
  assign bus.valido  = valido_q;
  assign bus.pronto  = pronto_q;
  assign bus.ocupado = ocupado_q;

endmodule

// File: tb/tb_gerador_papeis.sv
// Purpose: directed bench for gerador_papeis (default and 8-player/2-wolf/no-doctor builds).
// Latency: draws are timed from the accepting edge (CARREGA = cycle 1) to pronto.
// Backpressure: exercises sorteia ignored while busy and reset during a draw.
module tb_gerador_papeis;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  gerador_papeis_if #(.N_JOG(5)) bus_a ();
  gerador_papeis_if #(.N_JOG(8)) bus_b ();

  gerador_papeis dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  gerador_papeis #(.N_JOG(8), .N_LOBOS(2), .HAS_MEDICO(0)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference draw: returns the role vector and the pronto cycle index.
  function automatic void model(input logic [7:0] seed, input int n, input int nl, input int hm,
                                output logic [15:0] pap, output int lat);
    logic [7:0] r;
    int rem, c, pos;
    bit done;
    r   = (seed == 8'h00) ? 8'h01 : seed;
    pap = '0;
    rem = nl;
    lat = 1;
    while (rem > 0 && lat < 1000) begin
      lat++;
      c   = int'(r) % n;
      pos = 2 * (n - 1 - c);
      if (pap[pos +: 2] == 2'b00) begin
        pap[pos +: 2] = 2'b01;
        rem--;
      end
      r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    end
    done = (hm == 0);
    while (!done && lat < 1000) begin
      lat++;
      c   = int'(r) % n;
      pos = 2 * (n - 1 - c);
      if (pap[pos +: 2] == 2'b00) begin
        pap[pos +: 2] = 2'b10;
        done = 1'b1;
      end
      r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    end
    lat++;
  endfunction

  task automatic run_a(input logic [7:0] s, output logic [15:0] pap, output int lat);
    bus_a.seed    = s;
    bus_a.sorteia = 1'b1;
    @(posedge clock); #1;
    bus_a.sorteia = 1'b0;
    lat = 1;
    while (!bus_a.pronto && lat < 600) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!bus_a.pronto) check("timeout_a", 32'd0, 32'd1);
    pap = 16'(bus_a.papeis);
  endtask

  task automatic run_b(input logic [7:0] s, output logic [15:0] pap, output int lat);
    bus_b.seed    = s;
    bus_b.sorteia = 1'b1;
    @(posedge clock); #1;
    bus_b.sorteia = 1'b0;
    lat = 1;
    while (!bus_b.pronto && lat < 600) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!bus_b.pronto) check("timeout_b", 32'd0, 32'd1);
    pap = bus_b.papeis;
  endtask

  initial begin
    logic [15:0] pap, mpap;
    int lat, mlat, pulses, c01, c10;
    logic [1:0] exp_papel;

    bus_a.sorteia = 1'b0; bus_a.seed = 8'h00; bus_a.jogador = 3'd0;
    bus_b.sorteia = 1'b0; bus_b.seed = 8'h00; bus_b.jogador = 3'd0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_estado", 32'(bus_a.db_estado), 32'd0);
    check("rst_papeis", 32'(bus_a.papeis), 32'd0);
    check("rst_valido", 32'(bus_a.valido), 32'd0);
    check("rst_ocupado", 32'(bus_a.ocupado), 32'd0);
    check("rst_pronto", 32'(bus_a.pronto), 32'd0);
    check("rst_papeis_b", 32'(bus_b.papeis), 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("post_rst_estado", 32'(bus_a.db_estado), 32'd0);

    // seed 01: wolf at player 1, doctor at player 2, no collisions
    run_a(8'h01, pap, lat);
    check("s01_papeis", 32'(pap), 32'h060);
    check("s01_lat", 32'(lat), 32'd4);
    model(8'h01, 5, 1, 1, mpap, mlat);
    check("s01_model_papeis", 32'(pap), 32'(mpap));
    check("s01_model_lat", 32'(lat), 32'(mlat));
    check("s01_valido", 32'(bus_a.valido), 32'd1);
    check("s01_estado_fim", 32'(bus_a.db_estado), 32'd4);
    check("s01_ocupado_fim", 32'(bus_a.ocupado), 32'd0);
    pulses = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (bus_a.pronto) pulses++;
    end
    check("s01_pronto_once", 32'(pulses), 32'd0);
    check("s01_hold", 32'(bus_a.papeis), 32'h060);

    // seed 00 behaves as seed 01
    run_a(8'h00, pap, lat);
    check("s00_papeis", 32'(pap), 32'h060);
    check("s00_lat", 32'(lat), 32'd4);

    // seed 05: doctor collides once with the wolf at player 0
    run_a(8'h05, pap, lat);
    check("s05_papeis", 32'(pap), 32'h180);
    check("s05_lat", 32'(lat), 32'd5);
    model(8'h05, 5, 1, 1, mpap, mlat);
    check("s05_model_papeis", 32'(pap), 32'(mpap));
    check("s05_model_lat", 32'(lat), 32'(mlat));

    // Lookup sweep against the expected vector
    for (int j = 0; j < 8; j++) begin
      bus_a.jogador = 3'(j);
      #1;
      exp_papel = (j < 5) ? mpap[2 * (4 - j) +: 2] : 2'b00;
      check($sformatf("papel_j%0d", j), 32'(bus_a.papel), 32'(exp_papel));
    end

    // sorteia re-pulsed during LOBOS is ignored
    bus_a.seed = 8'h01; bus_a.sorteia = 1'b1;
    @(posedge clock); #1;
    bus_a.sorteia = 1'b0;
    check("rp_carrega", 32'(bus_a.db_estado), 32'd1);
    @(posedge clock); #1;
    check("rp_lobos", 32'(bus_a.db_estado), 32'd2);
    check("rp_ocupado", 32'(bus_a.ocupado), 32'd1);
    bus_a.seed = 8'h37; bus_a.sorteia = 1'b1;
    @(posedge clock); #1;
    bus_a.sorteia = 1'b0;
    check("rp_medico", 32'(bus_a.db_estado), 32'd3);
    lat = 3;
    while (!bus_a.pronto && lat < 600) begin
      @(posedge clock); #1;
      lat++;
    end
    check("rp_lat", 32'(lat), 32'd4);
    check("rp_papeis", 32'(bus_a.papeis), 32'h060);

    // Reset while in MEDICO discards the draw
    bus_a.seed = 8'h01; bus_a.sorteia = 1'b1;
    @(posedge clock); #1;
    bus_a.sorteia = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("rm_in_medico", 32'(bus_a.db_estado), 32'd3);
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    check("rm_estado", 32'(bus_a.db_estado), 32'd0);
    check("rm_papeis", 32'(bus_a.papeis), 32'd0);
    check("rm_valido", 32'(bus_a.valido), 32'd0);
    check("rm_ocupado", 32'(bus_a.ocupado), 32'd0);
    pulses = 0;
    if (bus_a.pronto) pulses++;
    repeat (6) begin
      @(posedge clock); #1;
      if (bus_a.pronto) pulses++;
    end
    check("rm_no_pronto", 32'(pulses), 32'd0);
    check("rm_idle", 32'(bus_a.db_estado), 32'd0);

    // 8 players, 2 wolves, no doctor: full seed sweep
    for (int s = 0; s < 256; s++) begin
      run_b(8'(s), pap, lat);
      model(8'(s), 8, 2, 0, mpap, mlat);
      c01 = 0;
      c10 = 0;
      for (int k = 0; k < 8; k++) begin
        if (pap[2 * k +: 2] == 2'b01) c01++;
        if (pap[2 * k +: 2] == 2'b10) c10++;
      end
      check($sformatf("b_s%0d_lobos", s), 32'(c01), 32'd2);
      check($sformatf("b_s%0d_medicos", s), 32'(c10), 32'd0);
      check($sformatf("b_s%0d_bound", s), 32'(lat <= 600), 32'd1);
      check($sformatf("b_s%0d_papeis", s), 32'(pap), 32'(mpap));
      check($sformatf("b_s%0d_lat", s), 32'(lat), 32'(mlat));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gerador_papeis.md
GERADOR_PAPEIS -- requirements
Module: gerador_papeis

Interface
REQ-001 Parameter N_JOG, default 5, number of players; legal range 3..8.
REQ-002 Parameter N_LOBOS, default 1, number of wolves; legal range 1..N_JOG-2.
REQ-003 Parameter HAS_MEDICO, default 1, selects whether one doctor is drawn (1) or not (0).
REQ-004 clock  input  1  single clock; all state changes on the rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 sorteia  input  1  one-cycle start request for a new draw.
REQ-007 seed  input  8  draw seed, sampled on an accepted sorteia.
REQ-008 jogador  input  3  player index for the lookup port.
REQ-009 papeis  output  2*N_JOG  role vector; player 0 in the two MSBs, player N_JOG-1 in the two LSBs.
REQ-010 papel  output  2  role of player jogador; 2'b00 when jogador >= N_JOG.
REQ-011 ocupado  output  1  high while a draw is in progress.
REQ-012 valido  output  1  high while papeis holds a completed draw.
REQ-013 pronto  output  1  one-cycle pulse when a draw completes.
REQ-014 db_estado  output  5  current FSM state code, for debug.

Function
REQ-015 Role encoding: 2'b00 aldeao, 2'b01 lobo, 2'b10 medico, 2'b11 reserved (never produced).
REQ-016 An 8-bit Fibonacci LFSR implements x^8+x^6+x^5+x^4+1, shifts left, and feeds back bit0 = b7^b5^b4^b3.
REQ-017 The candidate index is lfsr mod N_JOG, computed combinationally from the current LFSR value.
REQ-018 FSM state codes: IDLE=0, CARREGA=1, LOBOS=2, MEDICO=3, FIM=4; any other state code drives db_estado to 5'b11111 and returns the FSM to IDLE next cycle.
REQ-019 In IDLE or FIM, sorteia=1 moves the FSM to CARREGA; in CARREGA, LOBOS and MEDICO, sorteia is ignored.
REQ-020 On the edge that accepts sorteia, lfsr loads seed, or 8'h01 if seed==0.
REQ-021 CARREGA lasts one cycle, clears papeis to all-zero, clears valido, and loads the remaining-wolves counter with N_LOBOS.
REQ-022 From CARREGA the FSM always moves to LOBOS.
REQ-023 In each LOBOS cycle, if papeis[candidate] is aldeao, that slot is written to lobo and the counter decrements; otherwise nothing is written.
REQ-024 The LFSR advances once in every LOBOS cycle and every MEDICO cycle, whether or not the slot is written.
REQ-025 LOBOS exits when the last wolf is written: the FSM moves to MEDICO if HAS_MEDICO=1, else to FIM.
REQ-026 In a MEDICO cycle, if papeis[candidate] is aldeao, that slot is written to medico and the FSM moves to FIM; otherwise the FSM stays in MEDICO.
REQ-027 On entering FIM, pronto pulses for exactly one cycle and valido is set.
REQ-028 FIM holds papeis and valido until the next accepted sorteia.
REQ-029 Minimum latency from an accepted sorteia to pronto is 1+N_LOBOS+HAS_MEDICO+1 cycles.
REQ-030 Every collision adds one cycle of latency.
REQ-031 A draw always terminates, because the maximal-length 255-state LFSR covers every index for N_JOG<=8.
REQ-032 ocupado is high exactly in CARREGA, LOBOS and MEDICO.
REQ-033 A completed draw contains exactly N_LOBOS lobo codes, HAS_MEDICO medico codes, and aldeao in every other slot.
REQ-034 The same seed and parameters always produce the same papeis and the same latency.

Reset
REQ-035 With reset_n low at a rising edge, the FSM enters IDLE, papeis becomes 0, lfsr becomes 8'h01, the counter becomes 0, and valido, pronto and ocupado become 0.
REQ-036 Reset has priority over sorteia and over any draw in progress; a partial draw is discarded.
REQ-037 db_estado reads 0 in the cycle after reset.

Structure
REQ-038 Shared package polilobinho_pkg holds the role codes, the FSM state codes and the db_estado error code 5'b11111.
REQ-039 The LFSR is a sub-module named lfsr8 with ports clock, reset_n, carrega, valor, avanca and q.
REQ-040 The candidate-index modulo and the lookup multiplexer are local combinational logic.

Verification
REQ-041 Defaults, seed=8'h01, sorteia pulse -> pronto exactly once; papeis has one 01, one 10 and three 00; papeis matches the C reference model; latency matches the model cycle count (>=4).
REQ-042 seed=8'h00 -> papeis and latency identical to the seed=8'h01 result.
REQ-043 N_JOG=8, N_LOBOS=2, HAS_MEDICO=0, sweep seed over all 256 values -> every draw has exactly two 01 codes and no 10; no draw exceeds 600 cycles.
REQ-044 sorteia re-pulsed during LOBOS -> ignored; the final result equals the undisturbed run.
REQ-045 reset_n low for one cycle while in MEDICO -> next cycle state=0, papeis=0, valido=0; no pronto pulse.
REQ-046 After a completed draw, sweep jogador 0..7 -> papel equals the matching papeis slot; indices >= N_JOG return 2'b00.
